// File: rtl/set_sequencer_if.sv
// Button inputs and adjust/status outputs of the alarm-clock set sequencer.
interface set_sequencer_if;
  logic       mode_btn;
  logic       plus_btn;
  logic       minus_btn;
  logic       adj_inc;
  logic       adj_dec;
  logic [1:0] adj_target;
  logic       setting;
  logic       clk_hold;
  logic [2:0] state;

  modport master (
    output mode_btn, plus_btn, minus_btn,
    input  adj_inc, adj_dec, adj_target, setting, clk_hold, state
  );

  modport slave (
    input  mode_btn, plus_btn, minus_btn,
    output adj_inc, adj_dec, adj_target, setting, clk_hold, state
  );
endinterface

// File: rtl/set_sequencer.sv
// Button conditioning and set-mode sequencing for the alarm clock: turns raw
// mode/plus/minus buttons into single-cycle adjust pulses with auto-repeat.
module set_sequencer #(
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT      = 5000
) (
  input  logic           clk,
  input  logic           rst_n,
  set_sequencer_if.slave bus
);

  localparam int DW      = $clog2(DEB_CYCLES) + 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX) + 1;
  localparam int TW      = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_CH = 3'd1,
    SET_CM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } state_t;

  // Button vectors are ordered {minus, plus, mode}.
  logic [2:0]         raw_btn;
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;
  logic [2:0]         deb_q, deb_d;
  logic [2:0]         deb_prev_q, deb_prev_d;
  logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]         press;
  logic               mode_press, plus_lvl, minus_lvl;
  logic               in_set, lock_now, adj_ok;
  logic [RW-1:0]      rep_limit;
  state_t             state_q, state_d;
  logic               lockout_q, lockout_d;
  logic [RW-1:0]      rep_cnt_q, rep_cnt_d;
  logic               rep_fast_q, rep_fast_d;
  logic [TW-1:0]      idle_q, idle_d;
  logic               adj_inc_q, adj_inc_d;
  logic               adj_dec_q, adj_dec_d;
  logic [1:0]         adj_target_q, adj_target_d;
  logic               setting_q, setting_d;
  logic               clk_hold_q, clk_hold_d;

  always_comb begin
    raw_btn    = {bus.minus_btn, bus.plus_btn, bus.mode_btn};
    sync1_d    = raw_btn;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    deb_cnt_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] >= DW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press      = deb_q & ~deb_prev_q;
    mode_press = press[0];
    plus_lvl   = deb_q[1];
    minus_lvl  = deb_q[2];
    in_set     = (state_q != RUN);
    // Lockout persists until both adjust buttons are released.
    lock_now   = lockout_q | (plus_lvl & minus_lvl) | (mode_press & (plus_lvl | minus_lvl));
    lockout_d  = lock_now & (plus_lvl | minus_lvl);
    adj_ok     = in_set & ~mode_press & ~lock_now & (plus_lvl ^ minus_lvl);
    rep_limit  = rep_fast_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);

    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_CH;
        SET_CH:  state_d = SET_CM;
        SET_CM:  state_d = SET_AH;
        SET_AH:  state_d = SET_AM;
        default: state_d = RUN;
      endcase
    end else if (in_set && (idle_q >= TW'(TIMEOUT)) && !(|deb_q)) begin
      state_d = RUN;
    end

    if (!in_set || (|deb_q) || (state_d == RUN)) begin
      idle_d = '0;
    end else if (idle_q < TW'(TIMEOUT)) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end

    adj_inc_d  = 1'b0;
    adj_dec_d  = 1'b0;
    rep_cnt_d  = '0;
    rep_fast_d = 1'b0;
    // A non-zero repeat count means an initial pulse has been issued for this hold.
    if (adj_ok && (press[1] || press[2])) begin
      adj_inc_d = plus_lvl;
      adj_dec_d = minus_lvl;
      rep_cnt_d = RW'(1);
    end else if (adj_ok && (rep_cnt_q != '0)) begin
      if (rep_cnt_q >= rep_limit) begin
        adj_inc_d  = plus_lvl;
        adj_dec_d  = minus_lvl;
        rep_cnt_d  = RW'(1);
        rep_fast_d = 1'b1;
      end else begin
        rep_cnt_d  = rep_cnt_q + 1'b1;
        rep_fast_d = rep_fast_q;
      end
    end

    case (state_d)
      SET_CM:  adj_target_d = 2'b01;
      SET_AH:  adj_target_d = 2'b10;
      SET_AM:  adj_target_d = 2'b11;
      default: adj_target_d = 2'b00;
    endcase
    setting_d  = (state_d != RUN);
    clk_hold_d = (state_d == SET_CH) || (state_d == SET_CM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      deb_cnt_q    <= '0;
      state_q      <= RUN;
      lockout_q    <= 1'b0;
      rep_cnt_q    <= '0;
      rep_fast_q   <= 1'b0;
      idle_q       <= '0;
      adj_inc_q    <= 1'b0;
      adj_dec_q    <= 1'b0;
      adj_target_q <= 2'b00;
      setting_q    <= 1'b0;
      clk_hold_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      lockout_q    <= lockout_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_fast_q   <= rep_fast_d;
      idle_q       <= idle_d;
      adj_inc_q    <= adj_inc_d;
      adj_dec_q    <= adj_dec_d;
      adj_target_q <= adj_target_d;
      setting_q    <= setting_d;
      clk_hold_q   <= clk_hold_d;
    end
  end

  assign bus.adj_inc    = adj_inc_q;
  assign bus.adj_dec    = adj_dec_q;
  assign bus.adj_target = adj_target_q;
  assign bus.setting    = setting_q;
  assign bus.clk_hold   = clk_hold_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_set_sequencer.sv
// Bench for set_sequencer: directed table, hand-written corner sequences and
// random button activity compared every cycle against a behavioural model.
module tb_set_sequencer;
  localparam int DEB    = 4;
  localparam int RDELAY = 20;
  localparam int RRATE  = 5;
  localparam int TOUT   = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   inc_total = 0;
  int   dec_total = 0;

  set_sequencer_if bus();

  set_sequencer #(
    .DEB_CYCLES  (DEB),
    .REPEAT_DELAY(RDELAY),
    .REPEAT_RATE (RRATE),
    .TIMEOUT     (TOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw-sample history, elapsed-time repeat and last-activity timeout.
  logic [15:0] hist [3];
  logic [2:0]  m_deb, m_prev;
  int          m_st, rep_t0, last_busy, ecount;
  bit          m_lock, rep_on, m_inc, m_dec;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic modelStep();
    logic [2:0] raw, pre, prs;
    bit flip, plus, minus, any, in_set, mode_p, lock_now, ok, quiet;
    int el;
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) hist[b] = '0;
      m_deb = '0; m_prev = '0; m_st = 0; m_lock = 0; rep_on = 0;
      rep_t0 = 0; last_busy = 0; ecount = 0; m_inc = 0; m_dec = 0;
    end else begin
      ecount++;
      raw = {bus.minus_btn, bus.plus_btn, bus.mode_btn};
      pre = m_deb;
      prs = m_deb & ~m_prev;
      for (int b = 0; b < 3; b++) begin
        flip = 1'b1;
        for (int k = 1; k <= DEB; k++) if (hist[b][k] == pre[b]) flip = 1'b0;
        if (flip) m_deb[b] = ~pre[b];
        hist[b] = {hist[b][14:0], raw[b]};
      end
      m_prev   = pre;
      mode_p   = prs[0];
      plus     = pre[1];
      minus    = pre[2];
      any      = |pre;
      in_set   = (m_st != 0);
      lock_now = m_lock || (plus && minus) || (mode_p && (plus || minus));
      m_lock   = lock_now && (plus || minus);
      ok       = in_set && !mode_p && !lock_now && (plus != minus);
      m_inc = 0;
      m_dec = 0;
      if (ok && (prs[1] || prs[2])) begin
        m_inc = plus; m_dec = minus; rep_on = 1; rep_t0 = ecount;
      end else if (ok && rep_on) begin
        el = ecount - rep_t0;
        if (el >= RDELAY && ((el - RDELAY) % RRATE) == 0) begin
          m_inc = plus; m_dec = minus;
        end
      end else begin
        rep_on = 0;
      end
      quiet = in_set && !any;
      if (mode_p) m_st = (m_st + 1) % 5;
      else if (quiet && (ecount - 1 - last_busy) >= TOUT) m_st = 0;
      if (!quiet || m_st == 0) last_busy = ecount;
    end
  endtask

  // Inputs only change just after a falling edge, so here they still hold the values
  // sampled by the preceding rising edge.
  always @(negedge clk) begin
    logic [8:0] exp_vec, act_vec;
    modelStep();
    exp_vec = {3'(m_st), (m_st != 0), (m_st == 1 || m_st == 2),
               (m_st == 0) ? 2'd0 : 2'(m_st - 1), m_inc, m_dec};
    act_vec = {bus.state, bus.setting, bus.clk_hold, bus.adj_target, bus.adj_inc, bus.adj_dec};
    checkOutput("model", 32'(act_vec), 32'(exp_vec));
    if (bus.adj_inc === 1'b1) inc_total++;
    if (bus.adj_dec === 1'b1) dec_total++;
  end

  task automatic applyStimulus(input bit m, input bit p, input bit n, input int cycles);
    bus.mode_btn  = m;
    bus.plus_btn  = p;
    bus.minus_btn = n;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  typedef struct {
    bit mode;
    bit plus;
    bit minus;
    int hold;
    int rel;
    int exp_state;
    int exp_target;
    int exp_inc;
    int exp_dec;
  } step_t;

  step_t steps[13];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int inc_base, dec_base, waited;

    steps[0]  = '{1, 0, 0,  8, 10, 2, 1, 0, 0};
    steps[1]  = '{0, 1, 0, 10, 10, 2, 1, 1, 0};
    steps[2]  = '{0, 0, 1, 10, 10, 2, 1, 0, 1};
    steps[3]  = '{1, 0, 0,  8, 10, 3, 2, 0, 0};
    steps[4]  = '{0, 0, 1, 50, 10, 3, 2, 0, 7};
    steps[5]  = '{0, 1, 0, 25, 10, 3, 2, 2, 0};
    steps[6]  = '{1, 0, 0,  8, 10, 4, 3, 0, 0};
    steps[7]  = '{0, 1, 1, 12, 10, 4, 3, 0, 0};
    steps[8]  = '{1, 0, 0,  8, 10, 0, 0, 0, 0};
    steps[9]  = '{0, 1, 0, 10, 10, 0, 0, 0, 0};
    steps[10] = '{0, 0, 1, 40, 10, 0, 0, 0, 0};
    steps[11] = '{1, 0, 0,  8, 10, 1, 0, 0, 0};
    steps[12] = '{1, 1, 0, 10, 10, 2, 1, 0, 0};

    bus.mode_btn = 0; bus.plus_btn = 0; bus.minus_btn = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_state", 32'(bus.state), 0);
    checkOutput("rst_setting", 32'(bus.setting), 0);
    checkOutput("rst_clk_hold", 32'(bus.clk_hold), 0);
    checkOutput("rst_target", 32'(bus.adj_target), 0);
    checkOutput("rst_inc", 32'(bus.adj_inc), 0);
    checkOutput("rst_dec", 32'(bus.adj_dec), 0);
    rst_n = 1;

    applyStimulus(1, 0, 0, 3);
    applyStimulus(0, 0, 0, 12);
    checkOutput("glitch_state", 32'(bus.state), 0);

    bus.mode_btn = 1;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("lat_n5_state", 32'(bus.state), 0);
    @(negedge clk);
    #1;
    checkOutput("lat_n6_state", 32'(bus.state), 1);
    checkOutput("lat_n6_setting", 32'(bus.setting), 1);
    checkOutput("lat_n6_clk_hold", 32'(bus.clk_hold), 1);
    applyStimulus(1, 0, 0, 2);
    applyStimulus(0, 0, 0, 10);

    for (int i = 0; i < 13; i++) begin
      inc_base = inc_total;
      dec_base = dec_total;
      applyStimulus(steps[i].mode, steps[i].plus, steps[i].minus, steps[i].hold);
      applyStimulus(0, 0, 0, steps[i].rel);
      checkOutput($sformatf("step%0d_state", i), 32'(bus.state), 32'(steps[i].exp_state));
      checkOutput($sformatf("step%0d_target", i), 32'(bus.adj_target), 32'(steps[i].exp_target));
      checkOutput($sformatf("step%0d_inc", i), 32'(inc_total - inc_base), 32'(steps[i].exp_inc));
      checkOutput($sformatf("step%0d_dec", i), 32'(dec_total - dec_base), 32'(steps[i].exp_dec));
    end

    // Lockout from an overlapping minus press while plus is held, in SET_CM.
    inc_base = inc_total; dec_base = dec_total;
    applyStimulus(0, 1, 0, 10);
    applyStimulus(0, 1, 1, 10);
    applyStimulus(0, 1, 0, 30);
    applyStimulus(0, 0, 0, 10);
    checkOutput("lock_inc", 32'(inc_total - inc_base), 1);
    checkOutput("lock_dec", 32'(dec_total - dec_base), 0);
    inc_base = inc_total;
    applyStimulus(0, 1, 0, 10);
    applyStimulus(0, 0, 0, 10);
    checkOutput("unlock_inc", 32'(inc_total - inc_base), 1);

    inc_base = inc_total;
    applyStimulus(0, 1, 0, 8);
    applyStimulus(1, 1, 0, 10);
    applyStimulus(0, 1, 0, 30);
    applyStimulus(0, 0, 0, 10);
    checkOutput("mode_lock_inc", 32'(inc_total - inc_base), 1);
    checkOutput("mode_lock_state", 32'(bus.state), 3);

    applyStimulus(0, 0, 0, 60);
    checkOutput("to_ah_not_yet", 32'(bus.state), 3);
    waited = 0;
    while (bus.state !== 3'd0 && waited < 100) begin
      applyStimulus(0, 0, 0, 1);
      waited++;
    end
    checkOutput("to_ah_reached", 32'(bus.state), 0);

    applyStimulus(1, 0, 0, 8);
    applyStimulus(0, 0, 0, 10);
    checkOutput("ch_state", 32'(bus.state), 1);
    checkOutput("ch_clk_hold", 32'(bus.clk_hold), 1);
    applyStimulus(0, 0, 0, 60);
    checkOutput("to_ch_not_yet", 32'(bus.state), 1);
    waited = 0;
    while (bus.state !== 3'd0 && waited < 100) begin
      applyStimulus(0, 0, 0, 1);
      waited++;
    end
    checkOutput("to_ch_reached", 32'(bus.state), 0);
    checkOutput("to_ch_setting", 32'(bus.setting), 0);

    inc_base = inc_total; dec_base = dec_total;
    applyStimulus(0, 1, 0, 10);
    applyStimulus(0, 0, 0, 10);
    checkOutput("run_ignore_inc", 32'(inc_total - inc_base), 0);
    checkOutput("run_ignore_dec", 32'(dec_total - dec_base), 0);

    // Random button activity, including glitches and resets mid-hold.
    for (int s = 0; s < 160; s++) begin
      int r, len;
      bit m, p, n;
      r   = $urandom_range(0, 99);
      m   = (r < 14);
      p   = ($urandom_range(0, 2) == 0);
      n   = ($urandom_range(0, 3) == 0);
      len = (r % 6 == 0) ? $urandom_range(1, 5) : $urandom_range(3, 45);
      if (r >= 97) begin
        rst_n = 0;
        applyStimulus(m, p, n, 2);
        rst_n = 1;
      end
      applyStimulus(m, p, n, len);
    end
    applyStimulus(0, 0, 0, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/set_sequencer.md
Name: set_sequencer

Overview:
- Sequences time/alarm adjustment for the alarm-clock design from three raw push buttons (mode, plus, minus).
- Synchronises and debounces the buttons, runs a set-mode state machine, and issues single-cycle increment/decrement pulses aimed at one of four adjustable fields.
- Generates auto-repeat pulses while plus or minus is held.
- Sits between the board buttons and the clock/alarm hour/minute counters. Replaces free-running level steering with clocked, one-pulse-per-step control.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised samples required before the debounced level changes.
- REPEAT_DELAY, 500: cycles from the first pulse of a held button to the first repeat pulse.
- REPEAT_RATE, 100: cycles between subsequent repeat pulses.
- TIMEOUT, 5000: idle cycles in any set state before returning to RUN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- mode_btn  input  1  raw, asynchronous mode button; active high.
- plus_btn  input  1  raw, asynchronous plus button; active high.
- minus_btn  input  1  raw, asynchronous minus button; active high.
- adj_inc  output  1  one-cycle increment pulse to the field selected by adj_target.
- adj_dec  output  1  one-cycle decrement pulse to the field selected by adj_target.
- adj_target  output  2  field select: 00 clock hour, 01 clock minute, 10 alarm hour, 11 alarm minute.
- setting  output  1  high in any state other than RUN.
- clk_hold  output  1  high in SET_CH and SET_CM; freezes the seconds counter.
- state  output  3  current state encoding, for the display and debug.

Behaviour:
- Reset: sampled only on a clk edge while rst_n=0. All outputs are 0 and state=RUN (000). Synchronisers, debounced levels, and the repeat and timeout counters clear. Reset mid-hold or mid-setting behaves the same; after release, a still-held button counts as a new press only once it has debounced.
- Input conditioning, per button:
  - Two-flop synchroniser.
  - Debounce counter: counts while the synchronised value differs from the debounced level. It clears whenever the two agree. On reaching DEB_CYCLES the debounced level flips.
  - A press event is the registered rising edge of the debounced level.
  - Latency: raw rise first sampled at edge N gives the debounced level at edge N+1+DEB_CYCLES and the adj pulse at edge N+2+DEB_CYCLES, held for exactly one cycle.
- States and encodings: RUN=000, SET_CH=001, SET_CM=010, SET_AH=011, SET_AM=100.
  - A mode press advances RUN -> SET_CH -> SET_CM -> SET_AH -> SET_AM -> RUN.
  - adj_target is 00/01/10/11 for SET_CH/SET_CM/SET_AH/SET_AM. In RUN it is 00 and don't-care.
- Adjust, in SET states only:
  - A plus press gives one adj_inc pulse. A minus press gives one adj_dec pulse.
  - In RUN, plus and minus are ignored; no pulses are issued.
- Auto-repeat:
  - While the same single button stays debounced-high, the first repeat pulse fires REPEAT_DELAY cycles after the initial pulse.
  - Further pulses fire every REPEAT_RATE cycles.
  - Releasing the button clears the repeat counter.
- Conflicts:
  - adj_inc and adj_dec are never high in the same cycle.
  - If plus and minus are both debounced-high, no pulses are issued. A lockout flag sets and holds until both are debounced-low; a still-held single button after partial release does not resume.
  - A mode press while plus/minus is held also sets the lockout. The state advance on a mode press has priority.
  - If a mode press and a plus/minus press occur in the same cycle, the mode press wins and no adj pulse is issued.
- Timeout:
  - The idle counter runs in the SET states.
  - It clears on any press event and on every cycle while any debounced button is high.
  - At TIMEOUT it forces state to RUN on the next edge, with no pulse issued.
  - The counter saturates and does not wrap; it is held clear in RUN.
- Wrap-around of the hour/minute values is owned by the downstream counters; this block only pulses.
- Counter widths: $clog2 of the parameter + 1. All counters saturate.

Test Plan (bench parameters DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, TIMEOUT=100):
- Reset and glitch rejection: assert rst_n=0 for 3 cycles -> all outputs 0, state=000. Then pulse mode_btn high for 3 cycles -> state stays 000.
- Mode cycling and latency: press mode with raw rise sampled at edge N -> state=001 and setting=1 from edge N+2+DEB_CYCLES (N+6). Four more presses -> 010, 011, 100, 000. clk_hold=1 only in 001/010.
- Single step: in SET_CM, press plus for 10 cycles -> exactly one adj_inc pulse, 1 cycle wide, adj_target=01, adj_dec stays 0.
- Auto-repeat: in SET_AH, hold minus for 50 cycles after debounce -> adj_dec pulses at relative cycles 0, 20, 25, 30, 35, 40, 45 (7 pulses), adj_target=10.
- Conflict and lockout: hold plus, then press minus, then release minus while plus is held -> only the initial adj_inc, none afterward. Release both, press plus again -> one new pulse.
- Timeout and RUN ignore: enter SET_CH and idle 100 cycles -> state=000. Then press plus in RUN -> no adj pulse.
